// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose:
//   Bit-serial adder controller. A single 1-bit full-adder cell is reused
//   over WIDTH cycles to add two WIDTH-bit operands LSB first, using a
//   start/busy/done handshake towards the operand source and the consumer.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 2), default 8
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   busy   out  high while the adder is stepping through the bits
//   done   out  one-cycle pulse, sum/cout (and ovf) valid
//   sum    out  registered result, updated only on RUN->DONE
//   cout   out  registered carry-out, updated only on RUN->DONE
//   ovf    out  two's-complement overflow (only with SERIAL_ADD_OVF_EN)
//
// Configuration:
//   SERIAL_ADD_OVF_EN  when defined, adds the ovf port and overflow logic.
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The shared full-adder cell always looks at the current LSBs and carry.
  logic fa_s;
  logic fa_c;

  always_comb begin
    fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      // DONE accepts a new start exactly like IDLE so back-to-back ops
      // run with no idle bubble in between.
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on the last bit step.
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Purpose:
//   Directed self-checking bench for serial_add_ctrl with WIDTH=8. Expected
//   sums are hand-computed constants. The ovf port and its checks are only
//   present when SERIAL_ADD_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    stepClk();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting edges and busy cycles on the way.
  task automatic waitDone(output int edges, output int busyCycles,
                          output logic seen, output logic overlap);
    edges      = 0;
    busyCycles = 0;
    seen       = 1'b0;
    overlap    = 1'b0;
    while (!seen && edges <= 20) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busyCycles++;
        stepClk();
        edges++;
      end
    end
  endtask

  // Count done pulses over a number of cycles.
  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      stepClk();
      if (done) n++;
    end
  endtask

  task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic [7:0] expSum, input logic expCout,
                       input logic expOvf);
    int   edges;
    int   busyCycles;
    logic seen;
    logic overlap;
    applyStimulus(av, bv, cv);
    waitDone(edges, busyCycles, seen, overlap);
    checkOutput({tag, ".done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, ".latency"}, 32'(edges), 32'd8);
    checkOutput({tag, ".busy_cycles"}, 32'(busyCycles), 32'd8);
    checkOutput({tag, ".busy_done_overlap"}, 32'(overlap), 32'd0);
    checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, ".cout"}, 32'(cout), 32'(expCout));
`ifdef SERIAL_ADD_OVF_EN
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
`else
    if (expOvf === 1'bx) $display("[TB] note: unexpected ovf expectation");
`endif
  endtask

  initial begin
    int   edges;
    int   busyCycles;
    int   nDone;
    logic seen;
    logic overlap;

    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    stepClk();
    stepClk();

    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.sum", 32'(sum), 32'd0);
    checkOutput("reset.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("reset.ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    stepClk();

    // Basic adds and carry-out boundaries.
    runOp("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    stepClk();
    runOp("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    stepClk();
    runOp("add_ff_00_cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    stepClk();
    runOp("add_80_80_cin", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
    stepClk();
    runOp("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    stepClk();
    runOp("add_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    stepClk();

    // Start mid-run is ignored; operand changes after capture are ignored;
    // sum holds the previous result during the run.
    applyStimulus(8'h12, 8'h34, 1'b0);
    a   = 8'hAA;
    b   = 8'h55;
    cin = 1'b1;
    stepClk();
    stepClk();
    stepClk();
    checkOutput("midrun.sum_hold", 32'(sum), 32'h7F);
    a     = 8'h11;
    b     = 8'h22;
    start = 1'b1;
    stepClk();
    start = 1'b0;
    checkOutput("midrun.busy", 32'(busy), 32'd1);
    waitDone(edges, busyCycles, seen, overlap);
    checkOutput("midrun.done_seen", 32'(seen), 32'd1);
    checkOutput("midrun.remaining", 32'(edges), 32'd4);
    checkOutput("midrun.sum", 32'(sum), 32'h46);
    checkOutput("midrun.cout", 32'(cout), 32'd0);
    countDones(12, nDone);
    checkOutput("midrun.extra_done", 32'(nDone), 32'd0);
    checkOutput("midrun.idle_busy", 32'(busy), 32'd0);

    // Back-to-back: start held while done is high.
    applyStimulus(8'h10, 8'h20, 1'b0);
    waitDone(edges, busyCycles, seen, overlap);
    checkOutput("b2b.first_seen", 32'(seen), 32'd1);
    checkOutput("b2b.first_sum", 32'(sum), 32'h30);
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    start = 1'b1;
    stepClk();
    start = 1'b0;
    checkOutput("b2b.no_bubble", 32'(busy), 32'd1);
    waitDone(edges, busyCycles, seen, overlap);
    checkOutput("b2b.second_seen", 32'(seen), 32'd1);
    checkOutput("b2b.second_latency", 32'(edges), 32'd8);
    checkOutput("b2b.second_sum", 32'(sum), 32'h03);
    stepClk();

    // Reset during RUN cycle 4 aborts the op.
    applyStimulus(8'hF0, 8'h0F, 1'b1);
    stepClk();
    stepClk();
    stepClk();
    checkOutput("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    stepClk();
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.sum", 32'(sum), 32'd0);
    checkOutput("abort.cout", 32'(cout), 32'd0);
    rst = 1'b0;
    countDones(12, nDone);
    checkOutput("abort.no_done", 32'(nDone), 32'd0);

    // Reset and start in the same cycle: reset wins.
    runOp("pre_rst_start", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    rst   = 1'b1;
    stepClk();
    start = 1'b0;
    rst   = 1'b0;
    checkOutput("rst_start.busy", 32'(busy), 32'd0);
    checkOutput("rst_start.sum", 32'(sum), 32'd0);
    checkOutput("rst_start.cout", 32'(cout), 32'd0);
    stepClk();
    checkOutput("rst_start.still_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
